// File: rtl/minv_pkg.sv
// minv_pkg: shared definitions for the minv_param modular-inverse engine.
//   - State encoding for the IDLE / RUN / DONE controller.
//   - Default operand width and load/unload bus width.
package minv_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEF_WIDTH = 256;
  localparam int DEF_BUS   = 16;

endpackage

// File: rtl/minv_halve_mod.sv
// minv_halve_mod: combinational modular halving, y = x/2 mod p.
//   x  in  WIDTH  value in [0,p)
//   p  in  WIDTH  odd modulus
//   y  out WIDTH  x>>1 when x is even, (x+p)>>1 when x is odd
// The sum is formed at WIDTH+1 bits so the carry out of x+p is kept
// and becomes the top bit of the halved result.
module minv_halve_mod
  import minv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] sum;

  assign sum = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
  assign y   = sum[WIDTH:1];

endmodule

// File: rtl/minv_param.sv
// minv_param: modular inverse x = a^-1 mod p by binary extended Euclid,
// one reduction step per clock.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   datain   in   BUS-bit load word
//   load_a   in   shift datain into A from the top (first word ends at LSW)
//   load_p   in   shift datain into P from the top
//   start    in   single-cycle start pulse (ignored while running)
//   unload   in   shift result right by BUS bits (ignored while running)
//   dataout  out  result[BUS-1:0]
//   busy     out  high while reducing
//   done     out  high once a result is available, until next start/reset
//   err      out  no inverse exists (meaningful while done is high)
// Optional build macro MINV_PARAM_CHECK_EN: reject p even, p<=1 or a>=p
// at the start edge, going straight to DONE with err=1 and result 0.
module minv_param
  import minv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BUS   = DEF_BUS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [BUS-1:0] datain,
  input  logic           load_a,
  input  logic           load_p,
  input  logic           start,
  input  logic           unload,
  output logic [BUS-1:0] dataout,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg, p_reg;
  logic [WIDTH-1:0] u, v, x1, x2;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] x1_half, x2_half;

  // (a - b) mod m for a, b in [0,m): a borrow shows up in the extra top
  // bit, and adding m back (wrapping at WIDTH+1 bits) lands in range.
  function automatic logic [WIDTH-1:0] submod(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[WIDTH]) d = d + {1'b0, m};
    return d[WIDTH-1:0];
  endfunction

  minv_halve_mod #(.WIDTH(WIDTH)) u_half_x1 (.x(x1), .p(p_reg), .y(x1_half));
  minv_halve_mod #(.WIDTH(WIDTH)) u_half_x2 (.x(x2), .p(p_reg), .y(x2_half));

`ifdef MINV_PARAM_CHECK_EN
  logic bad_operands;
  assign bad_operands = !p_reg[0] || (p_reg <= ONE) || (a_reg >= p_reg);
`endif

  assign dataout = res[BUS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      p_reg <= '0;
      u     <= '0;
      v     <= '0;
      x1    <= '0;
      x2    <= '0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else if (state != RUN) begin
      if (load_a) a_reg <= {datain, a_reg[WIDTH-1:BUS]};
      if (load_p) p_reg <= {datain, p_reg[WIDTH-1:BUS]};
      if (unload) res <= res >> BUS;
      if (start) begin
        u     <= a_reg;
        v     <= p_reg;
        x1    <= ONE;
        x2    <= '0;
        done  <= 1'b0;
        err   <= 1'b0;
        busy  <= 1'b1;
        state <= RUN;
`ifdef MINV_PARAM_CHECK_EN
        if (bad_operands) begin
          res   <= '0;
          err   <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
`endif
      end
    end else begin
      // Invariants: x1*a == u and x2*a == v (mod p); the step that makes
      // u or v reach 1 leaves the inverse in the matching x register.
      if (u == ONE) begin
        res   <= x1;
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= DONE;
      end else if (v == ONE) begin
        res   <= x2;
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= DONE;
      end else if (u == '0 || v == '0) begin
        // gcd(a,p) > 1 (or a == 0): no inverse
        res   <= '0;
        err   <= 1'b1;
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= DONE;
      end else if (!u[0]) begin
        u  <= u >> 1;
        x1 <= x1_half;
      end else if (!v[0]) begin
        v  <= v >> 1;
        x2 <= x2_half;
      end else if (u >= v) begin
        u  <= u - v;
        x1 <= submod(x1, x2, p_reg);
      end else begin
        v  <= v - u;
        x2 <= submod(x2, x1, p_reg);
      end
    end
  end

endmodule
